// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle branch controller between decode and fetch
// Owns the fetch PC, carry flag, redirect/flush sequencing and link write strobe.
module branch_sequencer #(
  parameter int unsigned              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC     = '0,
  parameter int unsigned              PC_INC       = 4,
  parameter int unsigned              FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_link,
  input  logic [31:0]       alu_result,
  input  logic              alu_valid,
  input  logic              carry_we,
  input  logic              alu_carry,
  input  logic              pc_advance,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic              carry_q
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIRECT, S_FLUSH} state_t;

  state_t            r_state;
  logic [2:0]        r_cond;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_link_addr;
  logic              r_link;
  logic              r_carry;
  logic              r_resolve_nt;
  logic [CW-1:0]     r_cnt;
  logic              w_taken;

  // Condition uses the carry flag as it stood before this edge.
  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      3'b010:  w_taken = alu_result[31];
      3'b011:  w_taken = (alu_result == 32'd0);
      3'b100:  w_taken = (alu_result != 32'd0);
      3'b101:  w_taken = r_carry;
      3'b110:  w_taken = ~r_carry;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cond       <= 3'b000;
      r_target     <= '0;
      r_pc         <= RESET_PC;
      r_link_addr  <= '0;
      r_link       <= 1'b0;
      r_carry      <= 1'b0;
      r_resolve_nt <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_resolve_nt <= 1'b0;
      if (carry_we) r_carry <= alu_carry;
      case (r_state)
        S_IDLE: begin
          if (pc_advance) r_pc <= r_pc + PC_STEP;
          if (br_valid) begin
            r_cond      <= br_cond;
            r_target    <= br_target & ~ADDR_W'(3);
            r_link      <= br_link;
            r_link_addr <= br_pc + PC_STEP;
            case (br_cond)
              3'b000, 3'b111: r_resolve_nt <= 1'b1;
              3'b001:         r_state      <= S_REDIRECT;
              default:        r_state      <= S_EVAL;
            endcase
          end
        end
        S_EVAL: begin
          if (alu_valid) begin
            if (w_taken) begin
              r_state <= S_REDIRECT;
            end else begin
              r_state      <= S_IDLE;
              r_resolve_nt <= 1'b1;
            end
          end
        end
        S_REDIRECT: begin
          r_pc <= r_target;
          if (FLUSH_CYCLES > 1) begin
            r_state <= S_FLUSH;
            r_cnt   <= CW'(FLUSH_CYCLES - 2);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign br_ready      = (r_state == S_IDLE);
  assign stall         = (r_state != S_IDLE);
  assign redirect      = (r_state == S_REDIRECT);
  assign flush         = (r_state == S_REDIRECT) || (r_state == S_FLUSH);
  assign resolve_valid = r_resolve_nt || (r_state == S_REDIRECT);
  assign resolve_taken = (r_state == S_REDIRECT);
  assign link_we       = (r_state == S_REDIRECT) && r_link;
  assign link_addr     = r_link_addr;
  assign pc            = r_pc;
  assign carry_q       = r_carry;

endmodule
